// File: rtl/bit_counter_pre_rx_pkg.sv
// Shared types and constants for the serial frame collector.
package bit_counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned FRAME_BITS = 8;

    // Counter must hold the value DATA_W itself, not just DATA_W-1.
    function automatic int unsigned cnt_width(input int unsigned data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage

// File: rtl/bit_counter_pre_rx_if.sv
// Serial-in / parallel-out link bundle between the edge detector, collector and transmitter.
interface bit_counter_pre_rx_if
    import bit_counter_pkg::*;
#(
    parameter int unsigned DATA_W = FRAME_BITS
);
    logic              serial_in;
    logic              rise;
    logic              wake_transmitter;
    logic [DATA_W-1:0] pout;

    modport master (
        output serial_in,
        output rise,
        input  wake_transmitter,
        input  pout
    );

    modport slave (
        input  serial_in,
        input  rise,
        output wake_transmitter,
        output pout
    );
endinterface

// File: rtl/bit_counter_pre_rx_shift.sv
// DATA_W-bit shift register with enable and sync clear; BIT_COUNTER_LSB_FIRST_EN reverses direction.
module bit_shift_reg
    import bit_counter_pkg::*;
#(
    parameter int unsigned DATA_W = FRAME_BITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              shift_en,
    input  logic              din,
    output logic [DATA_W-1:0] word_c
);

    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (clr) begin
            data_d = '0;
        end else if (shift_en) begin
`ifdef BIT_COUNTER_LSB_FIRST_EN
            data_d = {din, data_q[DATA_W-1:1]};
`else
            data_d = {data_q[DATA_W-2:0], din};
`endif
        end
    end

    // Post-shift value lets the top capture the completed word on the final bit edge.
    assign word_c = data_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/bit_counter_pre_rx.sv
// Receive-side frame collector: after a rise strobe, samples DATA_W serial bits and presents them on pout.
// Bit order set by BIT_COUNTER_LSB_FIRST_EN (undefined: MSB first).
module bit_counter_pre_rx
    import bit_counter_pkg::*;
#(
    parameter int unsigned DATA_W = FRAME_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    bit_counter_pre_rx_if.slave  bus
);

    localparam int unsigned CNT_W = cnt_width(DATA_W);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] pout_q, pout_d;
    logic              wake_q, wake_d;
    logic              shift_en_c;
    logic              clr_c;
    logic [DATA_W-1:0] word_c;

    bit_shift_reg #(.DATA_W(DATA_W)) u_shift (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr_c),
        .shift_en (shift_en_c),
        .din      (bus.serial_in),
        .word_c   (word_c)
    );

    // Next-state, counter and output register inputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pout_d     = pout_q;
        wake_d     = 1'b0;
        shift_en_c = 1'b0;
        clr_c      = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.rise) begin
                    state_d = RECV;
                end
            end
            RECV: begin
                shift_en_c = 1'b1;
                cnt_d      = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    pout_d  = word_c;
                    wake_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                cnt_d   = '0;
                clr_c   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pout_q  <= '0;
            wake_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pout_q  <= pout_d;
            wake_q  <= wake_d;
        end
    end

    assign bus.pout             = pout_q;
    assign bus.wake_transmitter = wake_q;

endmodule

// File: tb/tb_bit_counter_pre_rx.sv
// Directed self-checking bench for bit_counter_pre_rx (honours BIT_COUNTER_LSB_FIRST_EN).
module tb_bit_counter_pre_rx;
    import bit_counter_pkg::*;

    localparam int unsigned DATA_W = 8;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    bit_counter_pre_rx_if #(.DATA_W(DATA_W)) bus ();

    bit_counter_pre_rx #(.DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #30 clk = ~clk;

    // Word as it should appear on pout when v is transmitted v[7] first.
    function automatic logic [7:0] exp_word(input logic [7:0] v);
        logic [7:0] r;
`ifdef BIT_COUNTER_LSB_FIRST_EN
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
`else
        r = v;
`endif
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Shift v out MSB first; optionally raise rise at bit edge rise_bit (1..8, 0 = never).
    task automatic send_bits(input logic [7:0] v, input logic [7:0] prev, input int rise_bit);
        for (int i = 0; i < 8; i++) begin
            bus.serial_in = v[7-i];
            bus.rise      = (i + 1 == rise_bit);
            tick();
            bus.rise = 1'b0;
            if (i < 7) begin
                check("partial_wake", 32'(bus.wake_transmitter), 32'd0);
                check("partial_pout", 32'(bus.pout), 32'(prev));
            end else begin
                check("done_wake", 32'(bus.wake_transmitter), 32'd1);
                check("done_pout", 32'(bus.pout), 32'(exp_word(v)));
            end
        end
    endtask

    task automatic start_frame();
        bus.rise = 1'b1;
        tick();
        bus.rise = 1'b0;
        check("start_state", 32'(dut.state_q), 32'(RECV));
    endtask

    initial begin
        tests         = 0;
        fails         = 0;
        rst           = 1'b1;
        bus.rise      = 1'b1;
        bus.serial_in = 1'b1;

        // Reset overrides rise
        tick();
        check("rst_pout", 32'(bus.pout), 32'd0);
        check("rst_wake", 32'(bus.wake_transmitter), 32'd0);
        check("rst_state", 32'(dut.state_q), 32'(IDLE));
        rst      = 1'b0;
        bus.rise = 1'b0;
        tick();
        check("idle_state", 32'(dut.state_q), 32'(IDLE));

        // Basic frame 11111000
        start_frame();
        send_bits(8'hF8, 8'h00, 0);
        tick();
        check("basic_wake_off", 32'(bus.wake_transmitter), 32'd0);
        check("basic_state_idle", 32'(dut.state_q), 32'(IDLE));

        // Hold with toggling serial_in
        for (int i = 0; i < 20; i++) begin
            bus.serial_in = ~bus.serial_in;
            tick();
            check("hold_pout", 32'(bus.pout), 32'(exp_word(8'hF8)));
            check("hold_wake", 32'(bus.wake_transmitter), 32'd0);
        end

        // Rise on 3rd bit edge is ignored
        start_frame();
        send_bits(8'hA5, exp_word(8'hF8), 3);
        tick();
        check("ign_wake_off", 32'(bus.wake_transmitter), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("ign_no_restart", 32'(dut.state_q), 32'(IDLE));
            check("ign_wake", 32'(bus.wake_transmitter), 32'd0);
            check("ign_pout", 32'(bus.pout), 32'(exp_word(8'hA5)));
        end

        // Mid-frame reset after 4 bits
        start_frame();
        for (int i = 0; i < 4; i++) begin
            bus.serial_in = 1'b1;
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_pout", 32'(bus.pout), 32'd0);
        check("mrst_wake", 32'(bus.wake_transmitter), 32'd0);
        check("mrst_state", 32'(dut.state_q), 32'(IDLE));
        for (int i = 0; i < 6; i++) begin
            tick();
            check("mrst_no_wake", 32'(bus.wake_transmitter), 32'd0);
        end
        start_frame();
        send_bits(8'h3C, 8'h00, 0);
        tick();
        tick();

        // Back-to-back: rise in DONE ignored, accepted on first IDLE edge
        start_frame();
        send_bits(8'h5A, exp_word(8'h3C), 0);
        bus.rise = 1'b1;
        tick();
        check("b2b_done_ignored", 32'(dut.state_q), 32'(IDLE));
        check("b2b_wake_off", 32'(bus.wake_transmitter), 32'd0);
        tick();
        bus.rise = 1'b0;
        check("b2b_accept", 32'(dut.state_q), 32'(RECV));
        send_bits(8'h81, exp_word(8'h5A), 0);
        tick();
        check("b2b_wake_off2", 32'(bus.wake_transmitter), 32'd0);
        check("b2b_pout_hold", 32'(bus.pout), 32'(exp_word(8'h81)));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
